fetch_ctrl: RTL and testbench

//  Front-end fetch sequencer. Owns the fetch PC and issues in-order requests to the icache

---
 rtl/fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer feeding an 8-entry instruction buffer from the icache.
// Ports: clk/rst, redirect_valid/redirect_pc in; ib_fetch_req in; ib_flush/ib_write_req/
// ib_pc/ib_inst/ib_exc out; inst_sram_req/addr out; inst_sram_addr_ok/data_ok/rdata in.
// Optional macro FETCH_ADEF_CHECK_EN: a misaligned fetch PC yields an ADEF entry and halts.
module fetch_ctrl #(
  parameter int          IB_SIZE   = 8,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ib_fetch_req,
  output logic        ib_flush,
  output logic        ib_write_req,
  output logic [31:0] ib_pc,
  output logic [31:0] ib_inst,
  output logic [2:0]  ib_exc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int CW = $clog2(IB_SIZE + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int PW = $clog2(MAX_OUTST);

  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] occ;
  logic [OW-1:0] outst, outst_d, stale, live, rq_cnt;

  logic [31:0]   pcq [MAX_OUTST];
  logic [PW-1:0] pcq_rd, pcq_wr;

  logic [31:0]   rq_pc   [MAX_OUTST];
  logic [31:0]   rq_inst [MAX_OUTST];
  logic [2:0]    rq_exc  [MAX_OUTST];
  logic [PW-1:0] rq_rd, rq_wr;

  logic        credit, misal, accept, drop, keep;
  logic        adef_push, rq_push, rq_pop;
  logic [31:0] push_pc, push_inst;
  logic [2:0]  push_exc;

  assign live = outst - stale;

  // Buffer room counts entries in the buffer, in the resp FIFO and
  // still in flight. The second term guarantees every live response
  // finds a resp FIFO slot even while the consumer blocks writes.
  assign credit = (state_q == RUN) && !redirect_valid && !rst
               && (int'(outst) < MAX_OUTST)
               && (int'(live) + int'(rq_cnt) < MAX_OUTST)
               && (int'(occ) + int'(live) + int'(rq_cnt) < IB_SIZE);

`ifdef FETCH_ADEF_CHECK_EN
  assign misal     = fetch_pc[1:0] != 2'b00;
  assign adef_push = credit && misal && outst == '0 && stale == '0;
`else
  assign misal     = 1'b0;
  assign adef_push = 1'b0;
`endif

  assign inst_sram_req  = credit && !misal;
  assign inst_sram_addr = fetch_pc;
  assign accept         = inst_sram_req && inst_sram_addr_ok;
  assign outst_d        = outst + OW'(accept) - OW'(inst_sram_data_ok);

  assign drop    = inst_sram_data_ok && stale != '0;
  assign keep    = inst_sram_data_ok && stale == '0;
  assign rq_push = keep || adef_push;

  assign push_pc   = keep ? pcq[pcq_rd] : fetch_pc;
  assign push_inst = keep ? inst_sram_rdata : '0;
  assign push_exc  = keep ? 3'b000 : 3'b001;

  assign ib_flush     = redirect_valid;
  assign ib_write_req = rq_cnt != '0 && !ib_fetch_req
                     && !redirect_valid && !rst;
  assign rq_pop       = ib_write_req;
  assign ib_pc        = rq_pc[rq_rd];
  assign ib_inst      = rq_inst[rq_rd];
  assign ib_exc       = rq_exc[rq_rd];

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = RUN;
    else if (adef_push)
      state_d = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      occ      <= '0;
      outst    <= '0;
      stale    <= '0;
      rq_cnt   <= '0;
      rq_rd    <= '0;
      rq_wr    <= '0;
      pcq_rd   <= '0;
      pcq_wr   <= '0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        pcq[i]     <= '0;
        rq_pc[i]   <= '0;
        rq_inst[i] <= '0;
        rq_exc[i]  <= '0;
      end
    end else begin
      outst <= outst_d;
      if (accept) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + PW'(1);
      end
      if (inst_sram_data_ok)
        pcq_rd <= pcq_rd + PW'(1);
      if (redirect_valid) begin
        // every request still in flight afterwards is now stale
        fetch_pc <= redirect_pc;
        occ      <= '0;
        stale    <= outst_d;
        rq_cnt   <= '0;
        rq_rd    <= '0;
        rq_wr    <= '0;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        occ <= occ + CW'(rq_pop) - (ib_fetch_req ? CW'(2) : CW'(0));
        if (drop)
          stale <= stale - OW'(1);
        if (rq_push) begin
          rq_pc[rq_wr]   <= push_pc;
          rq_inst[rq_wr] <= push_inst;
          rq_exc[rq_wr]  <= push_exc;
          rq_wr          <= rq_wr + PW'(1);
        end
        if (rq_pop)
          rq_rd <= rq_rd + PW'(1);
        rq_cnt <= rq_cnt + OW'(rq_push) - OW'(rq_pop);
      end
    end
  end

  a_pop_ok: assert property (
    @(posedge clk) disable iff (rst) ib_fetch_req |-> occ >= CW'(2)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with an in-order icache model
// and a scoreboard of expected buffer writes.
module tb_fetch_ctrl;

  localparam logic [31:0] KEY = 32'h13579bdf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  exc;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ib_fetch_req;
  logic        ib_flush;
  logic        ib_write_req;
  logic [31:0] ib_pc;
  logic [31:0] ib_inst;
  logic [2:0]  ib_exc;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        acc_en;
  logic        resp_en;
  logic [31:0] mem   [16];
  logic        smark [16];
  int          head;
  int          tail;

  ent_t        sb [$];
  logic [31:0] wlog_pc   [$];
  logic [31:0] wlog_inst [$];
  logic [2:0]  wlog_exc  [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_resp   = 0;
  int n_kept   = 0;
  int n_wr     = 0;

  fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .ib_fetch_req      (ib_fetch_req),
    .ib_flush          (ib_flush),
    .ib_write_req      (ib_write_req),
    .ib_pc             (ib_pc),
    .ib_inst           (ib_inst),
    .ib_exc            (ib_exc),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inst_sram_addr_ok = inst_sram_req && acc_en;
  assign inst_sram_data_ok = resp_en && (tail != head);
  assign inst_sram_rdata   = mem[head % 16] ^ KEY;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // icache model and scoreboard producer
  always @(posedge clk) begin
    if (rst) begin
      head <= 0;
      tail <= 0;
      sb.delete();
    end else begin
      if (inst_sram_data_ok) begin
        head <= head + 1;
        n_resp++;
        if (!smark[head % 16] && !redirect_valid) begin
          ent_t e;
          e.pc   = mem[head % 16];
          e.inst = mem[head % 16] ^ KEY;
          e.exc  = 3'b000;
          sb.push_back(e);
          n_kept++;
        end
      end
      if (inst_sram_req && inst_sram_addr_ok) begin
        mem[tail % 16]   <= inst_sram_addr;
        smark[tail % 16] <= 1'b0;
        tail <= tail + 1;
        n_acc++;
      end
      if (redirect_valid) begin
        sb.delete();
        for (int i = head; i < tail; i++)
          smark[i % 16] <= 1'b1;
      end
    end
  end

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && ib_write_req) begin
      n_wr++;
      wlog_pc.push_back(ib_pc);
      wlog_inst.push_back(ib_inst);
      wlog_exc.push_back(ib_exc);
      check("wr_vs_pop", 32'(ib_fetch_req), 32'd0);
      check("wr_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        ent_t e;
        e = sb.pop_front();
        check("wr_pc", ib_pc, e.pc);
        check("wr_inst", ib_inst, e.inst);
        check("wr_exc", 32'(ib_exc), 32'(e.exc));
      end
    end
  end

  initial begin
    int w0;
    int r0;
    int a0;
    logic [31:0] pa;

    for (int i = 0; i < 16; i++) begin
      mem[i]   = '0;
      smark[i] = 1'b0;
    end
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ib_fetch_req   = 1'b0;
    acc_en         = 1'b1;
    resp_en        = 1'b1;
    repeat (3) tick();

    check("rst_req", 32'(inst_sram_req), 32'd0);
    check("rst_wr", 32'(ib_write_req), 32'd0);
    check("rst_addr", inst_sram_addr, 32'hbfc00000);
    check("rst_pc", ib_pc, 32'd0);

    rst = 1'b0;
    #1;
    check("first_req", 32'(inst_sram_req), 32'd1);
    check("first_addr", inst_sram_addr, 32'hbfc00000);

    // fill the buffer with no pops
    repeat (40) tick();
    check("fill_wr", 32'(n_wr), 32'd8);
    check("fill_pc0", wlog_pc[0], 32'hbfc00000);
    check("fill_pc7", wlog_pc[7], 32'hbfc0001c);
    check("fill_req", 32'(inst_sram_req), 32'd0);
    repeat (10) tick();
    check("fill_acc", 32'(n_acc), 32'd8);

    // one pop frees exactly two slots
    ib_fetch_req = 1'b1;
    tick();
    ib_fetch_req = 1'b0;
    repeat (30) tick();
    check("pop_acc", 32'(n_acc), 32'd10);
    check("pop_pc8", wlog_pc[8], 32'hbfc00020);
    check("pop_pc9", wlog_pc[9], 32'hbfc00024);
    check("pop_req", 32'(inst_sram_req), 32'd0);

    // redirect with two requests outstanding
    resp_en      = 1'b0;
    ib_fetch_req = 1'b1;
    tick();
    ib_fetch_req = 1'b0;
    repeat (5) tick();
    check("r3_acc", 32'(n_acc), 32'd12);
    w0 = n_wr;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001000;
    #1;
    check("r3_flush", 32'(ib_flush), 32'd1);
    check("r3_noreq", 32'(inst_sram_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    #1;
    check("r3_flush_off", 32'(ib_flush), 32'd0);
    repeat (30) tick();
    check("r3_pc", wlog_pc[w0], 32'h80001000);
    check("r3_inst", wlog_inst[w0], 32'h80001000 ^ KEY);

    // response while the consumer pops: write is deferred
    resp_en      = 1'b0;
    ib_fetch_req = 1'b1;
    tick();
    ib_fetch_req = 1'b0;
    repeat (5) tick();
    resp_en = 1'b1;
    pa = mem[head % 16];
    #1;
    check("lat_wr", 32'(ib_write_req), 32'd0);
    tick();
    ib_fetch_req = 1'b1;
    #1;
    check("defer_wr", 32'(ib_write_req), 32'd0);
    tick();
    ib_fetch_req = 1'b0;
    #1;
    check("defer_wr1", 32'(ib_write_req), 32'd1);
    check("defer_pc", ib_pc, pa);
    check("defer_inst", ib_inst, pa ^ KEY);
    repeat (30) tick();
    check("defer_cnt", 32'(n_wr), 32'(n_kept));
    check("defer_sb", 32'(sb.size()), 32'd0);

    // redirect colliding with a response, two outstanding
    resp_en      = 1'b0;
    ib_fetch_req = 1'b1;
    tick();
    ib_fetch_req = 1'b0;
    repeat (5) tick();
    w0 = n_wr;
    r0 = n_resp;
    resp_en        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80002000;
    #1;
    check("r5_flush", 32'(ib_flush), 32'd1);
    check("r5_noreq", 32'(inst_sram_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    repeat (30) tick();
    check("r5_pc", wlog_pc[w0], 32'h80002000);
    check("r5_drop", 32'((n_resp - r0) - (n_wr - w0)), 32'd2);

    // back-to-back redirects: the last one wins
    resp_en      = 1'b0;
    ib_fetch_req = 1'b1;
    tick();
    ib_fetch_req = 1'b0;
    repeat (5) tick();
    w0 = n_wr;
    r0 = n_resp;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80004000;
    tick();
    redirect_pc = 32'h80003000;
    tick();
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    repeat (30) tick();
    check("bb_pc", wlog_pc[w0], 32'h80003000);
    check("bb_drop", 32'((n_resp - r0) - (n_wr - w0)), 32'd2);

    // misaligned fetch PC
    w0 = n_wr;
    a0 = n_acc;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000002;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ADEF_CHECK_EN
    begin
      ent_t e;
      e.pc   = 32'h80000002;
      e.inst = '0;
      e.exc  = 3'b001;
      sb.push_back(e);
      n_kept++;
    end
    #1;
    check("adef_noreq", 32'(inst_sram_req), 32'd0);
    repeat (10) tick();
    check("adef_acc", 32'(n_acc), 32'(a0));
    check("adef_wr", 32'(n_wr - w0), 32'd1);
    check("adef_pc", wlog_pc[w0], 32'h80000002);
    check("adef_exc", 32'(wlog_exc[w0]), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000000;
    tick();
    redirect_valid = 1'b0;
    repeat (30) tick();
    check("adef_resume", 32'(n_acc), 32'(a0 + 8));
    check("adef_res_pc", wlog_pc[w0 + 1], 32'h80000000);
`else
    #1;
    check("mis_req", 32'(inst_sram_req), 32'd1);
    check("mis_addr", inst_sram_addr, 32'h80000002);
    repeat (30) tick();
    check("mis_pc", wlog_pc[w0], 32'h80000002);
    check("mis_exc", 32'(wlog_exc[w0]), 32'd0);
    check("mis_acc", 32'(n_acc), 32'(a0 + 8));
`endif

    check("end_cnt", 32'(n_wr), 32'(n_kept));
    check("end_sb", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
